arcade_input_ctrl: RTL and testbench

Player-input front end for the Moon Patrol core. Merges PS/2 keyboard events and the two MiSTer joystick words into the 8-bit active-high control vector consumed by the game core's JOY input. It also generates a properly timed coin pulse, so the core sees one clean coin insertion per request, with guaranteed low time between insertions.

---
 rtl/moonpatrol_input_pkg.sv | 50 +++++
 rtl/coin_pulser.sv | 83 ++++++++
 rtl/arcade_input_ctrl.sv | 69 ++++++
 tb/tb_arcade_input_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/moonpatrol_input_pkg.sv
// Shared constants for the Moon Patrol player-input front end.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package moonpatrol_input_pkg;

    localparam int CNT_W = 22;

    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_JUMP   = 8'h29;
    localparam logic [7:0] SC_FIRE   = 8'h14;
    localparam logic [7:0] SC_START1 = 8'h05;
    localparam logic [7:0] SC_COIN   = 8'h06;

    localparam int JOY_RIGHT  = 0;
    localparam int JOY_LEFT   = 1;
    localparam int JOY_DOWN   = 2;
    localparam int JOY_UP     = 3;
    localparam int JOY_FIRE   = 4;
    localparam int JOY_JUMP   = 5;
    localparam int JOY_START1 = 6;
    localparam int JOY_COIN   = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } coin_state_t;

    // One-hot joy_out bit for a scancode; zero for codes the game ignores.
    function automatic logic [7:0] key_mask(input logic [7:0] sc);
        logic [7:0] m;
        m = '0;
        case (sc)
            SC_UP:     m[JOY_UP]     = 1'b1;
            SC_DOWN:   m[JOY_DOWN]   = 1'b1;
            SC_LEFT:   m[JOY_LEFT]   = 1'b1;
            SC_RIGHT:  m[JOY_RIGHT]  = 1'b1;
            SC_JUMP:   m[JOY_JUMP]   = 1'b1;
            SC_FIRE:   m[JOY_FIRE]   = 1'b1;
            SC_START1: m[JOY_START1] = 1'b1;
            SC_COIN:   m[JOY_COIN]   = 1'b1;
            default:   m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/coin_pulser.sv
// Turns coin_raw rising edges into fixed-width coin pulses with enforced low gap.
// Latency: rise seen at edge N enters PULSE at N+1.
// Backpressure: one request buffered while busy; further requests dropped.
module coin_pulser
    import moonpatrol_input_pkg::*;
#(
    parameter int unsigned COIN_PULSE = 3000000,
    parameter int unsigned COIN_GAP   = 3000000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic coin_raw,
    output logic coin,
    output logic busy
);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COIN_PULSE - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(COIN_GAP - 1);

    coin_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pending, pending_nxt;
    logic             coin_raw_q;
    logic             req;

    assign req = coin_raw & ~coin_raw_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            pending    <= 1'b0;
            coin_raw_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pending    <= pending_nxt;
            coin_raw_q <= coin_raw;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pending_nxt = pending;
        case (state)
            IDLE: begin
                // A request coinciding with a pending one is absorbed by this pulse.
                if (req || pending) begin
                    state_nxt   = PULSE;
                    cnt_nxt     = PULSE_LOAD;
                    pending_nxt = 1'b0;
                end
            end
            PULSE: begin
                if (req) pending_nxt = 1'b1;
                if (cnt == '0) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GAP: begin
                if (req) pending_nxt = 1'b1;
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                cnt_nxt     = '0;
                pending_nxt = 1'b0;
            end
        endcase
    end

    assign coin = (state == PULSE);
    assign busy = (state != IDLE) || pending;

endmodule

// File: rtl/arcade_input_ctrl.sv
// Merges PS/2 key events and two joystick words into the game's JOY vector.
// Latency: 1 cycle joystick->joy_out, key event at N visible at N+1, coin at N+2.
// Backpressure: none; coin requests beyond one pending are dropped.
module arcade_input_ctrl
    import moonpatrol_input_pkg::*;
#(
    parameter int unsigned COIN_PULSE = 3000000,
    parameter int unsigned COIN_GAP   = 3000000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    output logic [7:0]  joy_out,
    output logic        coin_busy
);

    logic [7:0] key_state;
    logic [7:0] mask;
    logic [7:0] joy;
    logic       key_tog;
    logic       armed;
    logic       coin_raw;
    logic       coin_lvl;
    logic       unused_in;

    // Upper pad bits and the E0 flag have no role in this game.
    assign unused_in = ^{joystick_0[15:8], joystick_1[15:8], ps2_key[8]};

    assign joy      = joystick_0[7:0] | joystick_1[7:0];
    assign mask     = key_mask(ps2_key[7:0]);
    assign coin_raw = key_state[JOY_COIN] | joy[JOY_COIN];

    // The first cycle after reset only syncs the toggle so a stale one is not an event.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            key_state <= '0;
            key_tog   <= 1'b0;
            armed     <= 1'b0;
        end else if (!armed) begin
            armed   <= 1'b1;
            key_tog <= ps2_key[10];
        end else if (ps2_key[10] != key_tog) begin
            key_tog   <= ps2_key[10];
            key_state <= (key_state & ~mask) | (mask & {8{ps2_key[9]}});
        end
    end

    coin_pulser #(
        .COIN_PULSE (COIN_PULSE),
        .COIN_GAP   (COIN_GAP)
    ) u_coin (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .coin_raw (coin_raw),
        .coin     (coin_lvl),
        .busy     (coin_busy)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            joy_out <= '0;
        end else begin
            joy_out <= {coin_lvl, key_state[6:0] | joy[6:0]};
        end
    end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Randomized and directed checks of arcade_input_ctrl against a time-based reference model.
module tb_arcade_input_ctrl;

    localparam int P = 4;
    localparam int G = 3;

    logic        clk_sys;
    logic        reset;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic [7:0]  joy_out;
    logic        coin_busy;

    arcade_input_ctrl #(.COIN_PULSE(P), .COIN_GAP(G)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_key    (ps2_key),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .joy_out    (joy_out),
        .coin_busy  (coin_busy)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errs   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: keys as a plain bit vector, coin pulses as start times.
    int         t;
    bit         m_armed;
    bit         m_tog;
    bit [7:0]   m_keys;
    bit         m_craw_prev;
    int         s_last;
    bit         pend;
    int         pend_at;
    logic [7:0] exp_joy;
    logic       exp_busy;

    function automatic int key_bit(input logic [7:0] sc);
        case (sc)
            8'h74: return 0;
            8'h6B: return 1;
            8'h72: return 2;
            8'h75: return 3;
            8'h14: return 4;
            8'h29: return 5;
            8'h05: return 6;
            8'h06: return 7;
            default: return -1;
        endcase
    endfunction

    task automatic model_rst();
        m_armed     = 0;
        m_tog       = 0;
        m_keys      = '0;
        m_craw_prev = 0;
        s_last      = -1000;
        pend        = 0;
        pend_at     = 0;
        exp_joy     = '0;
        exp_busy    = 1'b0;
    endtask

    task automatic model_edge();
        logic [7:0] j;
        bit         craw;
        bit         req;
        int         kb;
        t++;
        j    = joystick_0[7:0] | joystick_1[7:0];
        craw = m_keys[7] | j[7];
        req  = craw && !m_craw_prev;
        m_craw_prev = craw;
        if (pend && t == pend_at) begin
            s_last = t;
            pend   = 0;
        end else if (req) begin
            if (t >= s_last + P + G + 1) s_last = t;
            else if (!pend) begin
                pend    = 1;
                pend_at = s_last + P + G + 1;
            end
        end
        exp_joy[7]   = (t >= s_last + 1) && (t <= s_last + P);
        exp_joy[6:0] = m_keys[6:0] | j[6:0];
        exp_busy     = ((t >= s_last) && (t <= s_last + P + G - 1)) || pend;
        if (!m_armed) begin
            m_armed = 1;
            m_tog   = ps2_key[10];
        end else if (ps2_key[10] != m_tog) begin
            m_tog = ps2_key[10];
            kb    = key_bit(ps2_key[7:0]);
            if (kb >= 0) m_keys[kb] = ps2_key[9];
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        if (reset) model_rst();
        else model_edge();
        @(negedge clk_sys);
        chk("joy_out", {24'd0, joy_out}, {24'd0, exp_joy});
        chk("coin_busy", {31'd0, coin_busy}, {31'd0, exp_busy});
    endtask

    task automatic key_evt(input bit pressed, input bit ext, input logic [7:0] sc);
        ps2_key = {~ps2_key[10], pressed, ext, sc};
    endtask

    logic [7:0] codes [0:7];
    int         rises;
    int         first_rise;
    int         second_rise;
    int         high_cnt;
    logic       prev7;

    initial begin
        codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h05, 8'h06};
        t          = 0;
        reset      = 1'b1;
        ps2_key    = 11'h400;
        joystick_0 = '0;
        joystick_1 = '0;
        model_rst();
        repeat (3) step();
        chk("rst_joy", {24'd0, joy_out}, 32'h0);
        chk("rst_busy", {31'd0, coin_busy}, 32'h0);

        // Release with toggle already high: must not be taken as an event.
        reset = 1'b0;
        repeat (3) begin
            step();
            chk("arm_quiet", {24'd0, joy_out}, 32'h0);
        end

        // Up key, extended then plain.
        for (int e = 1; e >= 0; e--) begin
            key_evt(1, e[0], 8'h75);
            step();
            step();
            chk("up_press", {31'd0, joy_out[3]}, 32'h1);
            key_evt(0, e[0], 8'h75);
            step();
            step();
            chk("up_release", {31'd0, joy_out[3]}, 32'h0);
        end

        joystick_1 = 16'h0030;
        joystick_0 = 16'h0001;
        step();
        chk("joy_31", {24'd0, joy_out}, 32'h31);
        joystick_0 = '0;
        joystick_1 = '0;
        step();
        chk("joy_00", {24'd0, joy_out}, 32'h0);

        // F2 held for 20 cycles: one pulse of width P.
        key_evt(1, 0, 8'h06);
        high_cnt = 0;
        repeat (20) begin
            step();
            if (joy_out[7]) high_cnt++;
        end
        chk("coin_width", high_cnt, P);
        key_evt(0, 0, 8'h06);
        repeat (4) step();

        // Joystick coin requests at t=0, 3, 5: two pulses, 8 cycles apart.
        rises = 0;
        first_rise = -1;
        second_rise = -1;
        prev7 = 1'b0;
        for (int c = 0; c < 30; c++) begin
            joystick_0[7] = (c == 0 || c == 3 || c == 5);
            step();
            if (joy_out[7] && !prev7) begin
                rises++;
                if (first_rise < 0) first_rise = c;
                else if (second_rise < 0) second_rise = c;
            end
            prev7 = joy_out[7];
        end
        chk("coin_count", rises, 2);
        chk("coin_period", second_rise - first_rise, P + G + 1);

        // Reset in the middle of a pulse.
        joystick_0[7] = 1'b1;
        step();
        joystick_0[7] = 1'b0;
        step();
        step();
        chk("pre_rst_coin", {31'd0, joy_out[7]}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_async_coin", {31'd0, joy_out[7]}, 32'h0);
        chk("rst_async_busy", {31'd0, coin_busy}, 32'h0);
        model_rst();
        repeat (2) step();
        reset = 1'b0;
        high_cnt = 0;
        repeat (15) begin
            step();
            if (joy_out[7]) high_cnt++;
        end
        chk("no_pulse_after_rst", high_cnt, 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 4) == 0)
                    key_evt($urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom_range(0, 255)));
                else
                    key_evt($urandom_range(0, 1), $urandom_range(0, 1), codes[$urandom_range(0, 7)]);
            end
            if ($urandom_range(0, 5) == 0) joystick_0 = 16'($urandom);
            if ($urandom_range(0, 5) == 0) joystick_1 = 16'($urandom) & 16'hFF7F;
            if ($urandom_range(0, 2) == 0) joystick_0[7] = 1'b0;
            if (!reset && $urandom_range(0, 299) == 0) reset = 1'b1;
            else if (reset) reset = 1'b0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
